// File: rtl/cla_pipe_addsub.sv
// Pipelined add/subtract: one BLK-wide carry-lookahead block is resolved per stage,
// with a global stall driven by the output handshake.
module cla_pipe_addsub #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int NSEG = WIDTH / BLK;

    // Returns {carry into block MSB, carry out, sum}.
    function automatic logic [BLK+1:0] blk_add(input logic [BLK-1:0] x,
                                               input logic [BLK-1:0] y,
                                               input logic           cin);
        logic [BLK-1:0] g;
        logic [BLK-1:0] p;
        logic [BLK:0]   cy;
        logic           gg;
        logic           pp;
        g     = x & y;
        p     = x ^ y;
        cy    = '0;
        cy[0] = cin;
        gg    = 1'b0;
        pp    = 1'b1;
        // Prefix group generate/propagate, so every carry is a direct function of cin.
        for (int i = 0; i < BLK; i++) begin
            gg        = g[i] | (p[i] & gg);
            pp        = pp & p[i];
            cy[i + 1] = gg | (pp & cin);
        end
        return {cy[BLK-1], cy[BLK], p ^ cy[BLK-1:0]};
    endfunction

    logic [WIDTH-1:0] opa_q [NSEG];
    logic [WIDTH-1:0] opb_q [NSEG];
    logic [WIDTH-1:0] res_q [NSEG];
    logic [NSEG-1:0]  vld_q;
    logic [NSEG-1:0]  cy_q;
    logic [NSEG-1:0]  cm_q;
    logic [BLK+1:0]   blk_r [NSEG];
    logic [WIDTH-1:0] b_eff;
    logic             advance;

    assign advance   = !vld_q[NSEG-1] || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_q[NSEG-1];
    assign s         = res_q[NSEG-1];
    assign c         = cy_q[NSEG-1];
    assign ovf       = cy_q[NSEG-1] ^ cm_q[NSEG-1];

    always_comb begin
        b_eff = sub ? ~b : b;
        for (int k = 0; k < NSEG; k++) begin
            blk_r[k] = '0;
        end
        blk_r[0] = blk_add(a[BLK-1:0], b_eff[BLK-1:0], sub);
        for (int k = 1; k < NSEG; k++) begin
            blk_r[k] = blk_add(opa_q[k-1][k*BLK +: BLK], opb_q[k-1][k*BLK +: BLK], cy_q[k-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            cy_q  <= '0;
            cm_q  <= '0;
            for (int k = 0; k < NSEG; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
                res_q[k] <= '0;
            end
        end else if (advance) begin
            // Operand B is stored already inverted, so sub is not needed past stage 0.
            vld_q[0]  <= in_valid;
            opa_q[0]  <= a;
            opb_q[0]  <= b_eff;
            res_q[0]  <= WIDTH'(blk_r[0][BLK-1:0]);
            cy_q[0]   <= blk_r[0][BLK];
            cm_q[0]   <= blk_r[0][BLK+1];
            for (int k = 1; k < NSEG; k++) begin
                vld_q[k]                  <= vld_q[k-1];
                opa_q[k]                  <= opa_q[k-1];
                opb_q[k]                  <= opb_q[k-1];
                res_q[k]                  <= res_q[k-1];
                res_q[k][k*BLK +: BLK]    <= blk_r[k][BLK-1:0];
                cy_q[k]                   <= blk_r[k][BLK];
                cm_q[k]                   <= blk_r[k][BLK+1];
            end
        end
    end
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed and model-checked bench for cla_pipe_addsub (WIDTH=16, BLK=4).
module tb_cla_pipe_addsub;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] s;
    logic        c;
    logic        ovf;
    logic        out_valid;
    logic        out_ready;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [17:0] exp_word;
    logic [17:0] exp_q[$];
    logic        stall_prev = 1'b0;
    logic [17:0] held = '0;
    logic        lat_en = 1'b0;
    logic [3:0]  hist = '0;

    cla_pipe_addsub #(.WIDTH(16), .BLK(4)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .sub(sub),
        .in_valid(in_valid), .in_ready(in_ready),
        .s(s), .c(c), .ovf(ovf),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Expected {ovf, c, s} computed from integer arithmetic and sign rules.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic sb);
        logic [16:0] t;
        logic        v;
        if (sb) t = {1'b0, x} - {1'b0, y} + 17'h10000;
        else    t = {1'b0, x} + {1'b0, y};
        if (sb) v = (x[15] != y[15]) && (t[15] != x[15]);
        else    v = (x[15] == y[15]) && (t[15] != x[15]);
        return {v, t[16], t[15:0]};
    endfunction

    // Scoreboard and handshake-property monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            stall_prev = 1'b0;
            hist       = '0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 32'(out_valid), 32'(1));
                chk("hold_data", 32'({ovf, c, s}), 32'(held));
            end
            if (out_valid && !out_ready) chk("in_ready_stall", 32'(in_ready), 32'(0));
            if (out_valid && exp_q.size() == 0) chk("spurious", 32'(out_valid), 32'(0));
            else if (out_valid && out_ready) chk("result", 32'({ovf, c, s}), 32'(exp_q.pop_front()));
            if (in_valid && in_ready) exp_q.push_back(exp_word);
            if (lat_en) begin
                chk("bubble_lat", 32'(out_valid), 32'(hist[3]));
                hist = {hist[2:0], in_valid && in_ready};
            end else begin
                hist = '0;
            end
            stall_prev = out_valid && !out_ready;
            held       = {ovf, c, s};
        end
    end

    task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic sv, input logic [17:0] ev);
        logic took;
        took     = 1'b0;
        a        = av;
        b        = bv;
        sub      = sv;
        exp_word = ev;
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !took; t++) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
        end
        if (!took) chk("accept_timeout", 32'(took), 32'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        rst = 1'b1; a = '0; b = '0; sub = 1'b0; in_valid = 1'b0; out_ready = 1'b1; exp_word = '0;
        @(posedge clk); #1;
        in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_s", 32'(s), 32'(0));
        chk("rst_c_ovf", 32'({c, ovf}), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'(1));
        @(posedge clk); #1;

        // Full ripple, with explicit four-cycle latency.
        send(16'hFFFF, 16'h0001, 1'b0, {1'b0, 1'b1, 16'h0000});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("latency", 32'(out_valid), 32'(i == 3));
        end
        @(posedge clk); #1;
        send(16'h7FFF, 16'h0001, 1'b0, {1'b1, 1'b0, 16'h8000});
        send(16'h8000, 16'h0001, 1'b1, {1'b1, 1'b1, 16'h7FFF});
        send(16'h0003, 16'h0005, 1'b1, {1'b0, 1'b0, 16'hFFFE});
        send(16'h1234, 16'h4321, 1'b0, {1'b0, 1'b0, 16'h5555});
        send(16'hFFFF, 16'hFFFF, 1'b1, {1'b0, 1'b1, 16'h0000});
        send(16'h8000, 16'h8000, 1'b0, {1'b1, 1'b1, 16'h0000});
        drain();

        // Back-pressure on a six-deep stream.
        fork
            begin
                send(16'h0001, 16'h0002, 1'b0, {1'b0, 1'b0, 16'h0003});
                send(16'h00FF, 16'h0001, 1'b0, {1'b0, 1'b0, 16'h0100});
                send(16'h0F0F, 16'hF0F1, 1'b0, {1'b0, 1'b1, 16'h0000});
                send(16'h5000, 16'h3000, 1'b0, {1'b1, 1'b0, 16'h8000});
                send(16'h0010, 16'h0001, 1'b1, {1'b0, 1'b1, 16'h000F});
                send(16'h0000, 16'h0001, 1'b1, {1'b0, 1'b0, 16'hFFFF});
            end
            begin
                for (int i = 0; i < 14; i++) begin
                    out_ready = !(i >= 5 && i <= 8);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two results in flight: neither may appear.
        send(16'h1111, 16'h2222, 1'b0, {1'b0, 1'b0, 16'h3333});
        send(16'h4444, 16'h1111, 1'b1, {1'b0, 1'b1, 16'h3333});
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("flushed", 32'(out_valid), 32'(0));
        end
        @(posedge clk); #1;

        // Alternating bubbles against the reference model.
        lat_en = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rs;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            send(ra, rb, rs, model(ra, rb, rs));
            @(posedge clk); #1;
        end
        drain();
        lat_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
